// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the BCD display scanner.
// Contents: the scan FSM state enum and the active-low segment patterns.
// Bit order of every pattern is {g,f,e,d,c,b,a}.
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ONES     = 2'd1,
    TENS     = 2'd2,
    HUNDREDS = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
// Ports: digit (4-bit BCD in), seg (7-bit {g,f,e,d,c,b,a}, active low).
// Codes 4'hA..4'hF produce a dash so a corrupt digit is visible on the panel.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed three-digit 7-segment scanner for a cascaded BCD counter.
// Ports:
//   clk, reset   - single clock, synchronous active-high reset
//   enable       - 1 scans the display, 0 blanks it and idles
//   ones/tens/hundreds - BCD digits, snapshotted at the start of each frame
//   blank_lz     - 1 blanks leading zeros (hundreds, then tens)
//   seg          - active-low segments {g,f,e,d,c,b,a}, registered
//   an           - active-low digit enables {hundreds,tens,ones}, registered
//   frame_done   - one-cycle pulse after each completed three-digit frame
// Each digit is shown for SCAN_DIV cycles, order ONES -> TENS -> HUNDREDS.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam int PW = $clog2(SCAN_DIV);

  state_t        state, nstate;
  logic [PW-1:0] presc;
  logic [3:0]    snap_o, snap_t, snap_h;
  logic [3:0]    nxt_o, nxt_t, nxt_h;
  logic [3:0]    sel_digit;
  logic [6:0]    dec_seg;
  logic [2:0]    an_nxt;
  logic          last, load, wrap, blank;

  assign last = (presc == PW'(SCAN_DIV - 1));

  // Next-state decode. Outputs are registered on the same edge as the
  // state, so the digit shown next is selected from the next state and the
  // snapshot as it will be after this edge (fresh inputs on a reload).
  always_comb begin
    nstate = state;
    load   = 1'b0;
    wrap   = 1'b0;
    if (!enable) begin
      nstate = IDLE;
    end else begin
      case (state)
        IDLE:     begin nstate = ONES; load = 1'b1; end
        ONES:     if (last) nstate = TENS;
        TENS:     if (last) nstate = HUNDREDS;
        HUNDREDS: if (last) begin nstate = ONES; load = 1'b1; wrap = 1'b1; end
        default:  nstate = IDLE;
      endcase
    end

    nxt_o = load ? ones     : snap_o;
    nxt_t = load ? tens     : snap_t;
    nxt_h = load ? hundreds : snap_h;

    sel_digit = 4'd0;
    an_nxt    = 3'b111;
    case (nstate)
      ONES:     begin sel_digit = nxt_o; an_nxt = 3'b110; end
      TENS:     begin sel_digit = nxt_t; an_nxt = 3'b101; end
      HUNDREDS: begin sel_digit = nxt_h; an_nxt = 3'b011; end
      default:  begin sel_digit = 4'd0;  an_nxt = 3'b111; end
    endcase

    // Only a zero is ever blanked, so an invalid code always shows its dash.
    blank = blank_lz && (nxt_h == 4'd0) &&
            ((nstate == HUNDREDS) || (nstate == TENS && nxt_t == 4'd0));
  end

  bcd_to_7seg u_dec (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      presc      <= '0;
      snap_o     <= 4'd0;
      snap_t     <= 4'd0;
      snap_h     <= 4'd0;
      an         <= 3'b111;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state <= nstate;
      // Any state change (advance, start, drop to idle) restarts the count.
      presc <= (nstate == state && nstate != IDLE) ? presc + PW'(1) : '0;
      if (load) begin
        snap_o <= ones;
        snap_t <= tens;
        snap_h <= hundreds;
      end
      an         <= an_nxt;
      seg        <= (nstate == IDLE || blank) ? SEG_OFF : dec_seg;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
module tb_bcd_display_scanner;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset, enable, blank_lz;
  logic [3:0] ones, tens, hundreds;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  bcd_display_scanner #(.SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a time line of 3*SD cycles; the position is
  // the elapsed time divided by SD and digits come from a per-frame copy.
  logic [6:0] segtab [16];
  bit         active = 0;
  int         t = 0;
  int         pos = 0;
  int         sd_o, sd_t, sd_h;
  logic [6:0] exp_seg = 7'h7F;
  logic [2:0] exp_an  = 3'b111;
  logic       exp_fd  = 1'b0;

  initial begin
    segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
    segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
    segtab[8] = 7'h00; segtab[9] = 7'h10;
    for (int i = 10; i < 16; i++) segtab[i] = 7'h3F;
  end

  always @(posedge clk) begin
    exp_fd = 1'b0;
    if (reset || !enable) begin
      active = 0;
    end else if (!active) begin
      active = 1; t = 0;
      sd_o = ones; sd_t = tens; sd_h = hundreds;
    end else begin
      t = t + 1;
      if (t == 3 * SD) begin
        t = 0; exp_fd = 1'b1;
        sd_o = ones; sd_t = tens; sd_h = hundreds;
      end
    end
    if (!active) begin
      exp_an = 3'b111; exp_seg = 7'h7F;
    end else begin
      pos = t / SD;
      exp_an = ~(3'b001 << pos);
      if (pos == 0)      exp_seg = segtab[sd_o];
      else if (pos == 1) exp_seg = (blank_lz && sd_h == 0 && sd_t == 0) ? 7'h7F : segtab[sd_t];
      else               exp_seg = (blank_lz && sd_h == 0) ? 7'h7F : segtab[sd_h];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("an", 32'(an), 32'(exp_an));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
    end
  endtask

  task automatic set_digits(input int h, input int tn, input int o, input bit bl);
    hundreds = 4'(h); tens = 4'(tn); ones = 4'(o); blank_lz = bl;
  endtask

  // Advance until the display sits at the start of the TENS slot.
  task automatic goto_tens();
    int guard = 0;
    while (!(active && t == SD) && guard < 40) begin
      tick(1);
      guard++;
    end
    chk("reach_tens", 32'(active && t == SD), 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    set_digits(1, 2, 3, 0);
    @(negedge clk);
    tick(3);
    chk("reset_an", 32'(an), 32'd7);
    chk("reset_seg", 32'(seg), 32'h7F);

    reset = 1'b0;
    tick(1);
    chk("first_ones_an", 32'(an), 32'(3'b110));
    chk("first_ones_seg", 32'(seg), 32'(7'b0110000));
    tick(30);

    set_digits(0, 0, 7, 1);  tick(3 * SD * 2);
    set_digits(0, 5, 0, 1);  tick(3 * SD * 2);
    set_digits(0, 11, 4, 1); tick(3 * SD * 2);
    set_digits(2, 11, 4, 0); tick(3 * SD * 2);

    // Ones changes mid-frame and must only appear in the following frame.
    set_digits(1, 2, 3, 0);  tick(3 * SD);
    goto_tens();
    ones = 4'd9;
    tick(3 * SD * 2);

    // Enable dropped for two cycles during TENS.
    goto_tens();
    enable = 1'b0; tick(1);
    chk("dis_an", 32'(an), 32'd7);
    tick(1);
    enable = 1'b1; tick(SD);
    tick(3 * SD);

    // Reset pulse during TENS.
    goto_tens();
    reset = 1'b1; tick(1);
    chk("rst_mid_an", 32'(an), 32'd7);
    chk("rst_mid_seg", 32'(seg), 32'h7F);
    reset = 1'b0; tick(3 * SD);

    // Random traffic: biased toward zeros so blanking gets exercised.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        hundreds = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        tens     = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        ones     = 4'($urandom_range(0, 15));
        blank_lz = 1'($urandom_range(0, 1));
      end
      enable = ($urandom_range(0, 29) != 0);
      reset  = ($urandom_range(0, 59) == 0);
      tick(1);
    end
    reset = 1'b0; enable = 1'b1;
    tick(3 * SD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each digit is displayed; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  1 = scan the display; 0 = blank the display and go idle.
REQ-005 ones  input  4  BCD ones digit from the cascaded BCD counter.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 hundreds  input  4  BCD hundreds digit.
REQ-008 blank_lz  input  1  1 = blank leading zeros.
REQ-009 seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-010 an  output  3  active-low digit enables: an[0]=ones, an[1]=tens, an[2]=hundreds; at most one bit low.
REQ-011 frame_done  output  1  one-cycle pulse when a full three-digit frame completes.

Function
REQ-012 FSM states: IDLE, ONES, TENS, HUNDREDS.
REQ-013 IDLE with enable=1 sampled -> ONES on that edge, snapshot all three digits and clear the prescaler.
REQ-014 In a scan state, the prescaler counts 0..SCAN_DIV-1; when it reaches SCAN_DIV-1 the FSM advances ONES->TENS->HUNDREDS->ONES and the prescaler clears.
REQ-015 Each digit is displayed for exactly SCAN_DIV cycles.
REQ-016 On the HUNDREDS->ONES edge, the digit snapshot reloads and frame_done=1 for exactly one cycle; frame_done is 0 at all other times.
REQ-017 Displayed values come only from the snapshot; input changes mid-frame appear from the next frame.
REQ-018 enable=0 sampled in any scan state -> IDLE on that edge, with an=111 and seg=1111111; prescaler and position are not retained.
REQ-019 seg and an are registered and change on the same edge as the FSM state; there is no combinational path from the inputs.
REQ-020 Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 Invalid digits (4'hA..4'hF) display a dash, seg=0111111; an invalid digit is never blanked.
REQ-022 Blanking applies only when blank_lz=1:
- hundreds is blanked if snapshot hundreds==0;
- tens is blanked if snapshot hundreds==0 and tens==0;
- ones is never blanked.
REQ-023 A blanked digit keeps its an bit low with seg=1111111.
REQ-024 If reset and enable are both high, reset has priority.

Reset
REQ-025 On reset (any state, mid-frame included), on the next edge: state=IDLE, prescaler=0, snapshot=000, an=111, seg=1111111, frame_done=0.
REQ-026 After reset deasserts, scanning starts per REQ-013 only.

Structure
REQ-027 Shared package bcd_display_pkg holds:
- the FSM state enum;
- segment constants SEG_0..SEG_9, SEG_DASH and SEG_OFF.
REQ-028 One combinational sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out, dash for >9), is instantiated once, on the selected snapshot digit.
REQ-029 Prescaler width is $clog2(SCAN_DIV).

Verification (SCAN_DIV=4)
REQ-030 Reset held 3 cycles with enable=1 -> an=111, seg=1111111, frame_done=0 throughout.
REQ-031 enable=1, hundreds=1, tens=2, ones=3, blank_lz=0 -> display sequence with frame_done high 1 cycle at the wrap, repeating:
- 4 cycles an=110, seg=0110000;
- 4 cycles an=101, seg=0100100;
- 4 cycles an=011, seg=1111001.
REQ-032 blank_lz=1 with 0/0/7 -> hundreds and tens seg=1111111, ones seg=1111000; with 0/5/0 -> hundreds blank, tens 0010010, ones 1000000.
REQ-033 tens=4'hB -> the tens slot shows seg=0111111 regardless of blank_lz.
REQ-034 ones changed from 3 to 9 during the TENS slot -> the ones slot still shows 0110000 until after the next frame_done, then 0010000.
REQ-035 Mid-frame disturbances, each during the TENS slot:
- enable low 2 cycles -> an=111 on the next edge; on re-enable the frame restarts at ONES for a full 4 cycles;
- reset pulse -> same outputs as REQ-025.
